// File: rtl/spi_ram_pkg.sv
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared types and constants for the SPI-to-RAM bridge:
//                FSM state encoding, frame command codes, frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_ram_pkg;

   // SPI front-end FSM states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   // Command field carried in rx_data[9:8]
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Bits per deserialised frame (2-bit command + 8-bit payload)
   localparam int FRAME_LEN = 10;

   // Width of a memory word
   localparam int DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/spi_ram_mem.sv
// ============================================================================
//  Module      : spi_ram_mem
//  Description : 256x8 single-port RAM with command decoder. Holds the write
//                and read address registers, the read-address flag and the
//                registered read data with its one-cycle tx_valid strobe.
//                Optional macro SPI_RAM_MEM_CLR_EN clears the array on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_SIZE+1:0]   i_rx_data,
   input  logic                   i_rx_valid,
   output logic [DATA_W-1:0]      o_dout,
   output logic                   o_tx_valid,
   output logic                   o_rd_flag
);

   logic [DATA_W-1:0]    mem [MEM_DEPTH];

   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0]    dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 rd_flag_q, rd_flag_d;
   logic                 mem_we;

   // Decode a completed frame into address/data/read actions
   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      rd_flag_d  = rd_flag_q;
      mem_we     = 1'b0;
      if (i_rx_valid) begin
         case (i_rx_data[ADDR_SIZE+1:ADDR_SIZE])
            CMD_WR_ADDR: wr_addr_d = i_rx_data[ADDR_SIZE-1:0];
            CMD_WR_DATA: mem_we    = 1'b1;
            CMD_RD_ADDR: begin
               rd_addr_d = i_rx_data[ADDR_SIZE-1:0];
               rd_flag_d = 1'b1;
            end
            default: begin
               // Read-data command: payload is a don't-care
               dout_d     = mem[rd_addr_q];
               tx_valid_d = 1'b1;
               rd_flag_d  = 1'b0;
            end
         endcase
      end
   end

   // Control register file
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         rd_flag_q  <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         rd_flag_q  <= rd_flag_d;
      end
   end

`ifdef SPI_RAM_MEM_CLR_EN
   // Memory array write port, cleared to zero on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (mem_we) begin
         mem[wr_addr_q] <= i_rx_data[DATA_W-1:0];
      end
   end
`else
   // Memory array write port, no reset so a RAM macro can be inferred
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr_q] <= i_rx_data[DATA_W-1:0];
      end
   end
`endif

   assign o_dout     = dout_q;
   assign o_tx_valid = tx_valid_q;
   assign o_rd_flag  = rd_flag_q;

endmodule

`default_nettype wire

// File: rtl/spi_ram.sv
// ============================================================================
//  Module      : spi_ram
//  Description : SPI slave front end driving a 256x8 RAM. Deserialises
//                10-bit frames from MOSI while SS_n is low and serialises
//                read data MSB first onto a registered MISO.
//                Optional macro SPI_RAM_MEM_CLR_EN (see spi_ram_mem).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst_n,   // active-high synchronous reset despite its name
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   state_t               state_q, state_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [ADDR_SIZE+1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]    tx_sr_q, tx_sr_d;
   logic [2:0]           tx_cnt_q, tx_cnt_d;
   logic                 miso_q, miso_d;

   logic [DATA_W-1:0]    w_dout;
   logic                 w_tx_valid;
   logic                 w_rd_flag;

   // Next-state, receive shifter and transmit shifter
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_sr_d    = tx_sr_q;
      tx_cnt_d   = tx_cnt_q;
      miso_d     = 1'b0;

      if (SS_n) begin
         // Deselect aborts whatever is in flight
         state_d   = IDLE;
         bit_cnt_d = '0;
         tx_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = CHK_CMD;
               bit_cnt_d = '0;
            end
            CHK_CMD: begin
               if (!MOSI)          state_d = WRITE;
               else if (w_rd_flag) state_d = READ_DATA;
               else                state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               // Shift until a full frame is in; extra bits are ignored
               if (bit_cnt_q < 4'(FRAME_LEN)) begin
                  rx_data_d = {rx_data_q[ADDR_SIZE:0], MOSI};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'(FRAME_LEN - 1)) rx_valid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (state_q == READ_DATA) begin
            if (w_tx_valid) begin
               miso_d   = w_dout[DATA_W-1];
               tx_sr_d  = {w_dout[DATA_W-2:0], 1'b0};
               tx_cnt_d = 3'd7;
            end else if (tx_cnt_q != 3'd0) begin
               miso_d   = tx_sr_q[DATA_W-1];
               tx_sr_d  = {tx_sr_q[DATA_W-2:0], 1'b0};
               tx_cnt_d = tx_cnt_q - 3'd1;
            end
         end else begin
            tx_cnt_d = '0;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_sr_q    <= '0;
         tx_cnt_q   <= '0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_sr_q    <= tx_sr_d;
         tx_cnt_q   <= tx_cnt_d;
         miso_q     <= miso_d;
      end
   end

   spi_ram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .clk        (clk),
      .rst        (rst_n),
      .i_rx_data  (rx_data_q),
      .i_rx_valid (rx_valid_q),
      .o_dout     (w_dout),
      .o_tx_valid (w_tx_valid),
      .o_rd_flag  (w_rd_flag)
   );

   assign MISO = miso_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram.sv
// ============================================================================
//  Module      : tb_spi_ram
//  Description : Directed self-checking bench for spi_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_ram;
   import spi_ram_pkg::*;

   logic clk;
   logic rst_n;
   logic SS_n;
   logic MOSI;
   logic MISO;

   int vectors;
   int miscompares;

   // Per-cycle observations of the last frame, index = frame cycle number
   logic miso_seq [0:31];
   logic rxv_seq  [0:31];
   logic txv_seq  [0:31];

   spi_ram #(
      .MEM_DEPTH (256),
      .ADDR_SIZE (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .SS_n  (SS_n),
      .MOSI  (MOSI),
      .MISO  (MISO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one frame: SS_n low for len cycles, class bit at cycle 1,
   // bits[9..0] at cycles 2..11; then one deselect cycle.
   task automatic run_frame(input logic cls, input logic [9:0] bits, input int len);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         miso_seq[k] = MISO;
         rxv_seq[k]  = dut.rx_valid_q;
         txv_seq[k]  = dut.u_mem.tx_valid_q;
         SS_n = 1'b0;
         if (k == 1)                MOSI = cls;
         else if (k >= 2 && k < 12) MOSI = bits[11 - k];
         else                       MOSI = 1'b0;
      end
      @(negedge clk);
      miso_seq[len] = MISO;
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      SS_n  = 1'b1;
      MOSI  = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if (MISO !== 1'b0) begin
         $display("FAIL reset_miso: got %b want 0", MISO);
         miscompares++;
      end
      vectors++;
      if (dut.state_q !== IDLE) begin
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
         miscompares++;
      end
      vectors++;
      if (dut.u_mem.rd_flag_q !== 1'b0 || dut.u_mem.wr_addr_q !== 8'h00) begin
         $display("FAIL reset_regs: flag %b wr_addr %h want 0 00",
                  dut.u_mem.rd_flag_q, dut.u_mem.wr_addr_q);
         miscompares++;
      end
      rst_n = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_addr;
      run_frame(1'b0, 10'b00_1111_0000, 13);
      vectors++;
      if (dut.u_mem.wr_addr_q !== 8'hF0) begin
         $display("FAIL wr_addr: got %h want f0", dut.u_mem.wr_addr_q);
         miscompares++;
      end
      vectors++;
      if (rxv_seq[11] !== 1'b0 || rxv_seq[12] !== 1'b1) begin
         $display("FAIL rx_valid_timing: c11 %b c12 %b want 0 1", rxv_seq[11], rxv_seq[12]);
         miscompares++;
      end
   endtask

   task automatic test_write_data;
      run_frame(1'b0, 10'b01_1000_1010, 13);
      vectors++;
      if (dut.u_mem.mem[8'hF0] !== 8'h8A) begin
         $display("FAIL wr_data: mem[f0] got %h want 8a", dut.u_mem.mem[8'hF0]);
         miscompares++;
      end
   endtask

   task automatic test_read_addr;
      logic any_high;
      run_frame(1'b1, 10'b10_1111_0000, 13);
      vectors++;
      if (dut.u_mem.rd_addr_q !== 8'hF0 || dut.u_mem.rd_flag_q !== 1'b1) begin
         $display("FAIL rd_addr: addr %h flag %b want f0 1",
                  dut.u_mem.rd_addr_q, dut.u_mem.rd_flag_q);
         miscompares++;
      end
      any_high = 1'b0;
      for (int k = 0; k <= 13; k++) if (miso_seq[k] !== 1'b0) any_high = 1'b1;
      vectors++;
      if (any_high !== 1'b0) begin
         $display("FAIL rd_addr_miso: got activity want 0");
         miscompares++;
      end
   endtask

   // Read back and check serialised byte at cycles 14..21
   task automatic test_read_data(input logic [7:0] exp);
      logic [7:0] got;
      run_frame(1'b1, 10'b11_1000_1000, 24);
      for (int k = 0; k < 8; k++) got[7 - k] = miso_seq[14 + k];
      vectors++;
      if (got !== exp) begin
         $display("FAIL rd_data_miso: got %h want %h", got, exp);
         miscompares++;
      end
      vectors++;
      if (miso_seq[13] !== 1'b0 || miso_seq[22] !== 1'b0 || miso_seq[23] !== 1'b0) begin
         $display("FAIL rd_data_idle_miso: c13 %b c22 %b c23 %b want 0 0 0",
                  miso_seq[13], miso_seq[22], miso_seq[23]);
         miscompares++;
      end
      vectors++;
      if (txv_seq[12] !== 1'b0 || txv_seq[13] !== 1'b1 || txv_seq[14] !== 1'b0) begin
         $display("FAIL tx_valid_timing: c12 %b c13 %b c14 %b want 0 1 0",
                  txv_seq[12], txv_seq[13], txv_seq[14]);
         miscompares++;
      end
      vectors++;
      if (dut.u_mem.rd_flag_q !== 1'b0) begin
         $display("FAIL rd_flag_clear: got %b want 0", dut.u_mem.rd_flag_q);
         miscompares++;
      end
   endtask

   task automatic test_abort;
      run_frame(1'b0, 10'b00_0001_0000, 13);
      run_frame(1'b0, 10'b01_0101_0101, 13);
      // Only 2 command bits + 5 payload bits reach the slave
      run_frame(1'b0, 10'b01_1010_1010, 9);
      vectors++;
      if (dut.u_mem.mem[8'h10] !== 8'h55) begin
         $display("FAIL abort_mem: got %h want 55", dut.u_mem.mem[8'h10]);
         miscompares++;
      end
      vectors++;
      if (dut.state_q !== IDLE || dut.bit_cnt_q !== 4'd0) begin
         $display("FAIL abort_state: state %0d cnt %0d want 0 0", dut.state_q, dut.bit_cnt_q);
         miscompares++;
      end
      run_frame(1'b0, 10'b01_0011_1100, 13);
      vectors++;
      if (dut.u_mem.mem[8'h10] !== 8'h3C) begin
         $display("FAIL after_abort_mem: got %h want 3c", dut.u_mem.mem[8'h10]);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back;
      run_frame(1'b1, 10'b10_0001_0000, 13);
      test_read_data(8'h3C);
      // Address wrap boundary: last word
      run_frame(1'b0, 10'b00_1111_1111, 13);
      run_frame(1'b0, 10'b01_1100_0011, 13);
      run_frame(1'b1, 10'b10_1111_1111, 13);
      test_read_data(8'hC3);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] exp;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         SS_n = 1'b0;
         MOSI = (k == 1) ? 1'b0 : (k == 2 ? 1'b0 : (k == 3 ? 1'b1 : 1'b0));
      end
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      SS_n  = 1'b1;
      vectors++;
      if (dut.state_q !== IDLE || dut.bit_cnt_q !== 4'd0 || dut.rx_valid_q !== 1'b0) begin
         $display("FAIL rst_mid_state: state %0d cnt %0d rxv %b want 0 0 0",
                  dut.state_q, dut.bit_cnt_q, dut.rx_valid_q);
         miscompares++;
      end
`ifdef SPI_RAM_MEM_CLR_EN
      exp = 8'h00;
`else
      exp = 8'h8A;
`endif
      vectors++;
      if (dut.u_mem.mem[8'hF0] !== exp) begin
         $display("FAIL rst_mid_mem: got %h want %h", dut.u_mem.mem[8'hF0], exp);
         miscompares++;
      end
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write_addr();
      test_write_data();
      test_read_addr();
      test_read_data(8'h8A);
      test_abort();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_ram.md
# spi_ram

SPI slave front end coupled to a 256×8 single-port RAM, giving an external SPI master byte-wide write and read access to on-chip memory. Frames arrive on `MOSI` while `SS_n` is low. A 10-bit word (2-bit command + 8-bit payload) is deserialised and forwarded to the RAM. Read data returns serially on `MISO`. The block sits at the chip's SPI pin boundary; `clk` serves as both system clock and SPI bit clock.

## Interface
- `MEM_DEPTH`, 256: RAM words.
- `ADDR_SIZE`, 8: address width; `2**ADDR_SIZE == MEM_DEPTH`.
- `clk`  in  1  system/bit clock; all logic on rising edge.
- `rst_n`  in  1  reset. Synchronous and active-high despite the suffix; the name is kept as the codebase names it.
- `SS_n`  in  1  slave select, active-low; framing.
- `MOSI`  in  1  serial input, sampled on rising `clk`.
- `MISO`  out  1  serial output, registered.

## Operation
- FSM states: `IDLE`, `CHK_CMD`, `WRITE`, `READ_ADD`, `READ_DATA`.
- `IDLE`
  - `SS_n`=0 → `CHK_CMD`.
- `CHK_CMD` samples the frame-class bit on `MOSI`:
  - 0 → `WRITE`.
  - 1 and read-address flag clear → `READ_ADD`.
  - 1 and flag set → `READ_DATA`.
- `WRITE`/`READ_ADD`/`READ_DATA`:
  - Shift 10 bits MSB first into `rx_data[9:0]`.
  - On the 10th bit, pulse internal `rx_valid` for one cycle.
- RAM decodes `rx_data[9:8]` when `rx_valid`=1:
  - 00: `wr_addr` ← `rx_data[7:0]`.
  - 01: `mem[wr_addr]` ← `rx_data[7:0]`.
  - 10: `rd_addr` ← `rx_data[7:0]`; read-address flag set.
  - 11: `dout` ← `mem[rd_addr]`, `tx_valid` pulses; payload ignored; read-address flag cleared.
- `READ_DATA` after `tx_valid`: shift `dout[7]`…`dout[0]` onto `MISO`, one bit per cycle; then hold `MISO`=0 until `SS_n` rises.
- `SS_n`=1 in any state → `IDLE` next edge. The bit counter clears, and a partial frame is discarded with no RAM side effect.
- Reset values: FSM `IDLE`, `MISO`=0, counters 0, `wr_addr`/`rd_addr`/`dout` 0, flag clear, `rx_valid`/`tx_valid` 0.
- Reset mid-frame aborts the frame. RAM contents are preserved unless `SPI_RAM_MEM_CLR_EN` is defined.
- Addresses wrap naturally within 8 bits; out-of-range addresses are impossible.

## Timing
- Cycle 0: `SS_n` sampled low. Cycle 1: class bit. Cycles 2–11: `rx_data[9]`…`rx_data[0]`.
- `rx_valid` is high during cycle 12; the RAM write or address update takes effect at the end of cycle 12.
- Read data: `tx_valid`/`dout` valid at cycle 13. `MISO` carries `dout[7]` from cycle 14 through `dout[0]` at cycle 21.
- The master must keep `SS_n` low ≥22 cycles for read-data frames and ≥13 cycles for all other frames.
- `SS_n` high for one cycle between frames suffices.

## Configuration
- `SPI_RAM_MEM_CLR_EN`
  - Defined: reset clears all `MEM_DEPTH` words to 0x00 on the reset edge.
  - Undefined: memory is not reset (contents retained / X at power-up); this allows RAM macro inference.

## Structure
- Package `spi_ram_pkg`: FSM state enum, command codes (`CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11), frame length constant 10.
- Sub-module `spi_ram_mem`: RAM array, address registers, `dout`/`tx_valid`. The SPI FSM and shifters live in the top-level `spi_ram`.

## Test plan
- Reset held 10 cycles with `SS_n`=1 → `MISO`=0, FSM `IDLE`.
- Write address: class 0, bits 00_F0 → `wr_addr`=0xF0, memory unchanged.
- Write data: class 0, bits 01_8A → `mem[0xF0]`=0x8A.
- Read address: class 1, bits 10_F0 → `rd_addr`=0xF0, flag set, `MISO` stays 0.
- Read data: class 1, bits 11_88, `SS_n` low 22+ cycles → `MISO` serialises 1,0,0,0,1,0,1,0 (0x8A) at cycles 14–21; flag cleared.
- Abort: `SS_n` raised after 5 payload bits of a write-data frame → no memory change; the next full frame decodes correctly.
